// File: rtl/traffic_light_ctrl.sv
// Fixed-rotation traffic light controller with a latched pedestrian request.
// Rotation: all-red, main green/yellow, all-red, side green/yellow, optional walk.
// Phase timing counts ticks from a free-running prescaler, so every phase lasts
// exactly duration * TICK_DIV enabled cycles. Lamps decode from the state register only.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned T_GREEN  = 5,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_PED    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       ped_walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StAllRedA    = 3'd0,
    StMainGreen  = 3'd1,
    StMainYellow = 3'd2,
    StAllRedB    = 3'd3,
    StSideGreen  = 3'd4,
    StSideYellow = 3'd5,
    StPedWalk    = 3'd6,
    StIllegal    = 3'd7
  } state_e;

  localparam logic [15:0] TickMax  = 16'(TICK_DIV - 1);
  localparam logic [7:0]  LdGreen  = 8'(T_GREEN - 1);
  localparam logic [7:0]  LdYellow = 8'(T_YELLOW - 1);
  localparam logic [7:0]  LdAllRed = 8'(T_ALLRED - 1);
  localparam logic [7:0]  LdPed    = 8'(T_PED - 1);

  // Timer reload value for the phase being entered
  function automatic logic [7:0] phase_load(state_e s);
    logic [7:0] ld;
    case (s)
      StMainGreen,  StSideGreen:  ld = LdGreen;
      StMainYellow, StSideYellow: ld = LdYellow;
      StPedWalk:                  ld = LdPed;
      default:                    ld = LdAllRed;
    endcase
    return ld;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] presc_q, presc_d;
  logic        ped_pend_q, ped_pend_d;
  logic        ped_ack_q, ped_ack_d;
  logic        tick;
  logic        accept;
  logic        enter_walk;

  assign tick   = en & (presc_q == TickMax);
  assign accept = ped_req & ~ped_pend_q;

  // Prescaler free-runs while enabled; phase changes never clear it
  always_comb begin
    presc_d = presc_q;
    if (en) begin
      if (presc_q == TickMax) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Phase sequencing: leave a phase on the tick that finds the timer at zero
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == StIllegal) begin
      // Recover immediately, independent of enable
      state_d = StAllRedA;
      timer_d = LdAllRed;
    end else if (tick) begin
      if (timer_q == 8'd0) begin
        case (state_q)
          StAllRedA:    state_d = StMainGreen;
          StMainGreen:  state_d = StMainYellow;
          StMainYellow: state_d = StAllRedB;
          StAllRedB:    state_d = StSideGreen;
          StSideGreen:  state_d = StSideYellow;
          StSideYellow: state_d = ped_pend_q ? StPedWalk : StAllRedA;
          StPedWalk:    state_d = StAllRedA;
          default:      state_d = StAllRedA;
        endcase
        timer_d = phase_load(state_d);
      end else begin
        timer_d = timer_q - 8'd1;
      end
    end
  end

  // Pedestrian latch: one pending request at most, cleared as the walk starts
  always_comb begin
    enter_walk = (state_d == StPedWalk) && (state_q != StPedWalk);
    ped_pend_d = ped_pend_q;
    ped_ack_d  = accept;
    if (enter_walk) begin
      ped_pend_d = 1'b0;
    end else if (accept) begin
      ped_pend_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAllRedA;
      timer_q    <= LdAllRed;
      presc_q    <= '0;
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  // Lamp decode from the state register; red is the default for each road
  always_comb begin
    main_r   = 1'b1;
    main_y   = 1'b0;
    main_g   = 1'b0;
    side_r   = 1'b1;
    side_y   = 1'b0;
    side_g   = 1'b0;
    ped_walk = 1'b0;
    case (state_q)
      StMainGreen: begin
        main_r = 1'b0;
        main_g = 1'b1;
      end
      StMainYellow: begin
        main_r = 1'b0;
        main_y = 1'b1;
      end
      StSideGreen: begin
        side_r = 1'b0;
        side_g = 1'b1;
      end
      StSideYellow: begin
        side_r = 1'b0;
        side_y = 1'b1;
      end
      StPedWalk: ped_walk = 1'b1;
      default: ;
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign state   = state_q;

endmodule
